// File: rtl/gpio_conv_sequencer.sv
// -----------------------------------------------------------------------------
// gpio_conv_sequencer
//
// Bridges the MCU GPIO command word and the 2D-convolution datapath. The host
// drives a 3-bit command, a payload word and a slow level strobe, all of them
// asynchronous to CLK100MHZ. This block synchronises them and detects the
// strobe's rising edge. It then:
//   - writes kernel rows,
//   - latches the image size,
//   - streams pixels into the input line memories,
//   - launches the convolution,
//   - reads the results back onto the GPIO return word.
//
// Ports
//   CLK100MHZ      system clock
//   i_rst_n        asynchronous active-low reset
//   i_gpio_data    GPIO payload (async)
//   i_gpio_ctrl    command: 000 KERNEL, 001 SIZE, 010 LOAD, 100 LAST, 011 READ
//   i_gpio_valid   host strobe, level held for many clocks (async)
//   o_kernel_we    one-cycle kernel row write, with o_kernel_row/o_kernel_data
//   o_img_size     latched image size S
//   o_mem_we       one-cycle image write, with o_mem_sel/o_mem_addr/o_mem_wdata
//   o_conv_start   one-cycle convolution launch
//   i_conv_done    one-cycle convolution completion
//   o_rd_sel       result memory select
//   o_rd_addr      result memory address
//   i_rd_data      result memory data (1-cycle read latency)
//   o_gpio_out     result presented to GPIO
//   o_led          results ready
// -----------------------------------------------------------------------------
module gpio_conv_sequencer #(
    parameter int N       = 2,
    parameter int NB_DATA = 24,
    parameter int NB_ADDR = 10,
    parameter int NB_SEL  = 3,
    parameter int NB_OUT  = 13
) (
    input  logic               CLK100MHZ,
    input  logic               i_rst_n,
    input  logic [NB_DATA-1:0] i_gpio_data,
    input  logic [2:0]         i_gpio_ctrl,
    input  logic               i_gpio_valid,
    output logic               o_kernel_we,
    output logic [1:0]         o_kernel_row,
    output logic [NB_DATA-1:0] o_kernel_data,
    output logic [NB_ADDR-1:0] o_img_size,
    output logic               o_mem_we,
    output logic [NB_SEL-1:0]  o_mem_sel,
    output logic [NB_ADDR-1:0] o_mem_addr,
    output logic [NB_DATA-1:0] o_mem_wdata,
    output logic               o_conv_start,
    input  logic               i_conv_done,
    output logic [NB_SEL-1:0]  o_rd_sel,
    output logic [NB_ADDR-1:0] o_rd_addr,
    input  logic [NB_OUT-1:0]  i_rd_data,
    output logic [NB_OUT-1:0]  o_gpio_out,
    output logic               o_led
);

    localparam logic [2:0] CTRL_KERNEL = 3'b000;
    localparam logic [2:0] CTRL_SIZE   = 3'b001;
    localparam logic [2:0] CTRL_LOAD   = 3'b010;
    localparam logic [2:0] CTRL_LAST   = 3'b100;
    localparam logic [2:0] CTRL_READ   = 3'b011;

    // The first batch fills memories 0..N+1. Later batches reuse the two
    // overlap lines and only refill from memory 2 upward.
    localparam logic [NB_SEL-1:0] SEL_FIRST  = {NB_SEL{1'b0}};
    localparam logic [NB_SEL-1:0] SEL_SECOND = NB_SEL'(2'd2);
    localparam logic [NB_SEL-1:0] SEL_LAST   = NB_SEL'(N + 1);
    localparam logic [NB_SEL-1:0] SEL_LIMIT  = NB_SEL'(N + 2);
    localparam logic [NB_SEL-1:0] RD_SEL_END = NB_SEL'(N - 1);
    localparam logic [1:0]        KROW_MAX   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KLOAD = 3'd1,
        ST_ILOAD = 3'd2,
        ST_RUN   = 3'd3,
        ST_READY = 3'd4
    } state_t;

    state_t state_r;
    state_t state_nxt_s;

    logic [2:0]         ctrl_s1_r;
    logic [2:0]         ctrl_s2_r;
    logic               valid_s1_r;
    logic               valid_s2_r;
    logic               valid_prev_r;
    logic [NB_DATA-1:0] data_s1_r;
    logic [NB_DATA-1:0] data_s2_r;

    logic               vld_rise_s;
    logic               is_kernel_s;
    logic               is_size_s;
    logic               is_load_s;
    logic               is_last_s;
    logic               is_read_s;

    logic [1:0]         krow_r;
    logic               kernel_wr_s;

    logic [NB_ADDR-1:0] col_r;
    logic [NB_SEL-1:0]  sel_r;
    logic [NB_ADDR-1:0] col_eff_s;
    logic [NB_SEL-1:0]  sel_eff_s;
    logic               load_entry_s;
    logic               mem_wr_s;
    logic               last_wr_s;
    logic               first_batch_r;
    logic               start_pend_r;

    logic [NB_ADDR-1:0] rd_addr_end_s;
    logic               rd_wrap_s;
    logic               rd_sat_s;
    logic               rd_adv_s;
    logic               rd_clear_s;

    assign vld_rise_s  = valid_s2_r & ~valid_prev_r;
    assign is_kernel_s = (ctrl_s2_r == CTRL_KERNEL);
    assign is_size_s   = (ctrl_s2_r == CTRL_SIZE);
    assign is_load_s   = (ctrl_s2_r == CTRL_LOAD);
    assign is_last_s   = (ctrl_s2_r == CTRL_LAST);
    assign is_read_s   = (ctrl_s2_r == CTRL_READ);

    assign kernel_wr_s = vld_rise_s & is_kernel_s;

    // Each result memory holds S-1 valid words, so the read pointer wraps at S-2.
    assign rd_addr_end_s = o_img_size - NB_ADDR'(2'd2);
    assign rd_wrap_s     = (o_rd_addr == rd_addr_end_s);
    assign rd_sat_s      = rd_wrap_s & (o_rd_sel == RD_SEL_END);
    assign rd_adv_s      = vld_rise_s & is_read_s & (state_r == ST_READY);
    assign rd_clear_s    = is_load_s & (state_r == ST_READY);

    // Two-flop synchronisers for the host inputs, plus the strobe history flop.
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ctrl_s1_r    <= 3'b000;
            ctrl_s2_r    <= 3'b000;
            valid_s1_r   <= 1'b0;
            valid_s2_r   <= 1'b0;
            valid_prev_r <= 1'b0;
            data_s1_r    <= {NB_DATA{1'b0}};
            data_s2_r    <= {NB_DATA{1'b0}};
        end else begin
            ctrl_s1_r    <= i_gpio_ctrl;
            ctrl_s2_r    <= ctrl_s1_r;
            valid_s1_r   <= i_gpio_valid;
            valid_s2_r   <= valid_s1_r;
            valid_prev_r <= valid_s2_r;
            data_s1_r    <= i_gpio_data;
            data_s2_r    <= data_s1_r;
        end
    end

    // Kernel row writes.
    // krow is held at 0 whenever the command is not KERNEL, so a fresh KERNEL
    // sequence always starts at row 0. This also holds when the strobe arrives
    // together with the command change.
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) begin
            krow_r        <= 2'd0;
            o_kernel_we   <= 1'b0;
            o_kernel_row  <= 2'd0;
            o_kernel_data <= {NB_DATA{1'b0}};
        end else begin
            o_kernel_we <= kernel_wr_s;
            if (kernel_wr_s) begin
                o_kernel_row  <= krow_r;
                o_kernel_data <= data_s2_r;
            end else begin
                o_kernel_row  <= o_kernel_row;
                o_kernel_data <= o_kernel_data;
            end
            if (!is_kernel_s) begin
                krow_r <= 2'd0;
            end else if (kernel_wr_s && (krow_r != KROW_MAX)) begin
                krow_r <= krow_r + 2'd1;
            end else begin
                krow_r <= krow_r;
            end
        end
    end

    // The image size is level-sampled: it follows the payload for as long as
    // the command is SIZE, and needs no strobe.
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_img_size <= {NB_ADDR{1'b0}};
        end else if (is_size_s) begin
            o_img_size <= data_s2_r[NB_ADDR-1:0];
        end else begin
            o_img_size <= o_img_size;
        end
    end

    // Resolve the write target for this cycle.
    // On LOAD entry the counters restart, so a strobe arriving in the same
    // cycle as the command change lands on the first address.
    always_comb begin
        load_entry_s = 1'b0;
        col_eff_s    = col_r;
        sel_eff_s    = sel_r;
        mem_wr_s     = 1'b0;
        last_wr_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_KLOAD, ST_READY: load_entry_s = is_load_s;
            default:                     load_entry_s = 1'b0;
        endcase
        if (load_entry_s) begin
            col_eff_s = {NB_ADDR{1'b0}};
            sel_eff_s = first_batch_r ? SEL_FIRST : SEL_SECOND;
        end else begin
            col_eff_s = col_r;
            sel_eff_s = sel_r;
        end
        if (vld_rise_s && (load_entry_s ||
            ((state_r == ST_ILOAD) && (is_load_s || is_last_s)))) begin
            mem_wr_s = 1'b1;
        end else begin
            mem_wr_s = 1'b0;
        end
        if (vld_rise_s && (state_r == ST_ILOAD) && is_last_s) begin
            last_wr_s = 1'b1;
        end else begin
            last_wr_s = 1'b0;
        end
    end

    // Image write port and column/memory counters.
    // Each memory takes S+1 words. Writes past the last input memory are
    // dropped, and the select counter parks at N+2.
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_r       <= {NB_ADDR{1'b0}};
            sel_r       <= {NB_SEL{1'b0}};
            o_mem_we    <= 1'b0;
            o_mem_sel   <= {NB_SEL{1'b0}};
            o_mem_addr  <= {NB_ADDR{1'b0}};
            o_mem_wdata <= {NB_DATA{1'b0}};
        end else begin
            o_mem_we <= mem_wr_s & (sel_eff_s <= SEL_LAST);
            if (mem_wr_s) begin
                o_mem_sel   <= sel_eff_s;
                o_mem_addr  <= col_eff_s;
                o_mem_wdata <= data_s2_r;
                if (col_eff_s == o_img_size) begin
                    col_r <= {NB_ADDR{1'b0}};
                    sel_r <= (sel_eff_s >= SEL_LIMIT) ? SEL_LIMIT : sel_eff_s + NB_SEL'(1'b1);
                end else begin
                    col_r <= col_eff_s + NB_ADDR'(1'b1);
                    sel_r <= sel_eff_s;
                end
            end else if (load_entry_s) begin
                o_mem_sel   <= o_mem_sel;
                o_mem_addr  <= o_mem_addr;
                o_mem_wdata <= o_mem_wdata;
                col_r       <= col_eff_s;
                sel_r       <= sel_eff_s;
            end else begin
                o_mem_sel   <= o_mem_sel;
                o_mem_addr  <= o_mem_addr;
                o_mem_wdata <= o_mem_wdata;
                col_r       <= col_r;
                sel_r       <= sel_r;
            end
        end
    end

    // Launch the convolution one cycle after the final (LAST) write is issued.
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) begin
            start_pend_r  <= 1'b0;
            o_conv_start  <= 1'b0;
            first_batch_r <= 1'b1;
        end else begin
            start_pend_r <= last_wr_s;
            o_conv_start <= start_pend_r;
            if (last_wr_s) begin
                first_batch_r <= 1'b0;
            end else begin
                first_batch_r <= first_batch_r;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_KLOAD: begin
                if (is_load_s) begin
                    state_nxt_s = ST_ILOAD;
                end else if (is_kernel_s) begin
                    state_nxt_s = ST_KLOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ILOAD: begin
                if (last_wr_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_ILOAD;
                end
            end
            ST_RUN: begin
                if (i_conv_done) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_READY: begin
                if (is_load_s) begin
                    state_nxt_s = ST_ILOAD;
                end else begin
                    state_nxt_s = ST_READY;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Results-ready indicator.
    // It is set only by a completion that arrives while running, and cleared
    // when the next batch begins loading.
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_led <= 1'b0;
        end else if ((state_r == ST_RUN) && i_conv_done) begin
            o_led <= 1'b1;
        end else if (rd_clear_s) begin
            o_led <= 1'b0;
        end else begin
            o_led <= o_led;
        end
    end

    // Readback pointer and GPIO return word.
    // The pointer drives the result memory directly, so o_gpio_out follows an
    // address change two cycles later. The pointer saturates on the last word.
    always_ff @(posedge CLK100MHZ or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_rd_sel   <= {NB_SEL{1'b0}};
            o_rd_addr  <= {NB_ADDR{1'b0}};
            o_gpio_out <= {NB_OUT{1'b0}};
        end else begin
            if (rd_clear_s) begin
                o_rd_sel  <= {NB_SEL{1'b0}};
                o_rd_addr <= {NB_ADDR{1'b0}};
            end else if (rd_adv_s && !rd_sat_s) begin
                if (rd_wrap_s) begin
                    o_rd_sel  <= o_rd_sel + NB_SEL'(1'b1);
                    o_rd_addr <= {NB_ADDR{1'b0}};
                end else begin
                    o_rd_sel  <= o_rd_sel;
                    o_rd_addr <= o_rd_addr + NB_ADDR'(1'b1);
                end
            end else begin
                o_rd_sel  <= o_rd_sel;
                o_rd_addr <= o_rd_addr;
            end
            if ((state_r == ST_READY) && is_read_s) begin
                o_gpio_out <= i_rd_data;
            end else begin
                o_gpio_out <= o_gpio_out;
            end
        end
    end

endmodule

// File: tb/tb_gpio_conv_sequencer.sv
module tb_gpio_conv_sequencer;

    logic        clk;
    logic        rst_n;
    logic [23:0] gpio_data;
    logic [2:0]  gpio_ctrl;
    logic        gpio_valid;
    logic        kernel_we;
    logic [1:0]  kernel_row;
    logic [23:0] kernel_data;
    logic [9:0]  img_size;
    logic        mem_we;
    logic [2:0]  mem_sel;
    logic [9:0]  mem_addr;
    logic [23:0] mem_wdata;
    logic        conv_start;
    logic        conv_done;
    logic [2:0]  rd_sel;
    logic [9:0]  rd_addr;
    logic [12:0] rd_data;
    logic [12:0] gpio_out;
    logic        led;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] C_KERNEL = 3'b000;
    localparam logic [2:0] C_SIZE   = 3'b001;
    localparam logic [2:0] C_LOAD   = 3'b010;
    localparam logic [2:0] C_LAST   = 3'b100;
    localparam logic [2:0] C_READ   = 3'b011;
    localparam logic [2:0] C_NOP    = 3'b111;

    gpio_conv_sequencer dut (
        .CLK100MHZ    (clk),
        .i_rst_n      (rst_n),
        .i_gpio_data  (gpio_data),
        .i_gpio_ctrl  (gpio_ctrl),
        .i_gpio_valid (gpio_valid),
        .o_kernel_we  (kernel_we),
        .o_kernel_row (kernel_row),
        .o_kernel_data(kernel_data),
        .o_img_size   (img_size),
        .o_mem_we     (mem_we),
        .o_mem_sel    (mem_sel),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_conv_start (conv_start),
        .i_conv_done  (conv_done),
        .o_rd_sel     (rd_sel),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .o_gpio_out   (gpio_out),
        .o_led        (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result memory model: a word encodes its own {sel, addr}, returned one cycle later.
    always @(posedge clk) rd_data <= {rd_sel, rd_addr};

    // Event recorders (observation only, no checking here).
    logic [2:0]  wr_sel  [0:255];
    logic [9:0]  wr_addr [0:255];
    logic [23:0] wr_data [0:255];
    int          wr_cnt = 0;
    logic [1:0]  k_row   [0:15];
    logic [23:0] k_data  [0:15];
    int          k_cnt = 0;
    int          start_cnt = 0;
    int          start_after_we = 0;
    logic        prev_we = 1'b0;

    always @(negedge clk) begin
        if (mem_we && wr_cnt < 256) begin
            wr_sel[wr_cnt]  = mem_sel;
            wr_addr[wr_cnt] = mem_addr;
            wr_data[wr_cnt] = mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
        if (kernel_we && k_cnt < 16) begin
            k_row[k_cnt]  = kernel_row;
            k_data[k_cnt] = kernel_data;
            k_cnt = k_cnt + 1;
        end
        if (conv_start) begin
            start_cnt = start_cnt + 1;
            if (prev_we) start_after_we = start_after_we + 1;
        end
        prev_we = mem_we;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [23:0] d);
        gpio_data = d;
        cycles(1);
        gpio_valid = 1'b1;
        cycles(4);
        gpio_valid = 1'b0;
        cycles(4);
    endtask

    int base;
    int bad;

    initial begin
        rst_n      = 1'b0;
        gpio_data  = 24'h0;
        gpio_ctrl  = C_NOP;
        gpio_valid = 1'b0;
        conv_done  = 1'b0;
        cycles(3);
        // Reset state
        check("rst_led", {31'd0, led}, 32'd0);
        check("rst_start", {31'd0, conv_start}, 32'd0);
        check("rst_we", {30'd0, mem_we, kernel_we}, 32'd0);
        check("rst_size", {22'd0, img_size}, 32'd0);
        check("rst_rd", {19'd0, rd_sel, rd_addr}, 32'd0);
        check("rst_gpio", {19'd0, gpio_out}, 32'd0);
        rst_n = 1'b1;
        cycles(2);

        // Completion outside RUN is ignored
        conv_done = 1'b1; cycles(1); conv_done = 1'b0; cycles(3);
        check("done_idle_led", {31'd0, led}, 32'd0);

        // 1. Kernel rows
        gpio_ctrl = C_KERNEL;
        cycles(4);
        strobe(24'h002000);
        strobe(24'h208020);
        strobe(24'h002000);
        strobe(24'h123456);
        check("k_cnt", k_cnt, 32'd4);
        check("k_row0", {30'd0, k_row[0]}, 32'd0);
        check("k_row1", {30'd0, k_row[1]}, 32'd1);
        check("k_row2", {30'd0, k_row[2]}, 32'd2);
        check("k_row3_sat", {30'd0, k_row[3]}, 32'd2);
        check("k_data1", {8'd0, k_data[1]}, 32'h208020);
        check("k_data3", {8'd0, k_data[3]}, 32'h123456);

        // 2. Level-sampled size, no strobe
        gpio_ctrl = C_SIZE;
        gpio_data = 24'd15;
        cycles(3);
        check("size_3clk", {22'd0, img_size}, 32'd15);

        // 3. First batch load: 63 LOAD strobes + 1 LAST strobe
        gpio_ctrl = C_LOAD;
        cycles(4);
        base = wr_cnt;
        for (int i = 0; i < 63; i++) strobe(24'(i));
        gpio_ctrl = C_LAST;
        cycles(4);
        strobe(24'd63);
        cycles(4);
        check("b1_wr_cnt", wr_cnt - base, 32'd64);
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            if (wr_sel[base+i] !== 3'(i / 16) || wr_addr[base+i] !== 10'(i % 16) ||
                wr_data[base+i] !== 24'(i)) bad = bad + 1;
        end
        check("b1_wr_pattern_bad", bad, 32'd0);
        check("b1_wr15", {19'd0, wr_sel[base+15], wr_addr[base+15]}, {19'd0, 3'd0, 10'd15});
        check("b1_wr63", {19'd0, wr_sel[base+63], wr_addr[base+63]}, {19'd0, 3'd3, 10'd15});
        check("b1_start_cnt", start_cnt, 32'd1);
        check("b1_start_after_we", start_after_we, 32'd1);

        // RUN ignores LOAD strobes
        gpio_ctrl = C_LOAD;
        cycles(4);
        strobe(24'hABC);
        check("run_ignore_load", wr_cnt - base, 32'd64);
        gpio_ctrl = C_NOP;
        cycles(4);
        check("run_led_low", {31'd0, led}, 32'd0);

        // 4. Completion and readback
        cycles(36);
        conv_done = 1'b1; cycles(1); conv_done = 1'b0; cycles(2);
        check("led_set", {31'd0, led}, 32'd1);
        gpio_ctrl = C_READ;
        cycles(6);
        check("rd_first", {19'd0, gpio_out}, 32'h000);
        strobe(24'd0);
        check("rd_addr1", {22'd0, rd_addr}, 32'd1);
        check("rd_gpio1", {19'd0, gpio_out}, 32'h001);
        for (int i = 0; i < 13; i++) strobe(24'd0);
        check("rd_wrap_sel", {29'd0, rd_sel}, 32'd1);
        check("rd_wrap_addr", {22'd0, rd_addr}, 32'd0);
        check("rd_wrap_gpio", {19'd0, gpio_out}, 32'h400);
        for (int i = 0; i < 13; i++) strobe(24'd0);
        check("rd_last_gpio", {19'd0, gpio_out}, 32'h40D);
        for (int i = 0; i < 3; i++) strobe(24'd0);
        check("rd_sat_sel", {29'd0, rd_sel}, 32'd1);
        check("rd_sat_addr", {22'd0, rd_addr}, 32'd13);
        check("rd_sat_gpio", {19'd0, gpio_out}, 32'h40D);

        // 5. Second batch starts at memory 2
        gpio_ctrl = C_LOAD;
        cycles(6);
        check("b2_led_clr", {31'd0, led}, 32'd0);
        check("b2_rd_clr", {19'd0, rd_sel, rd_addr}, 32'd0);
        base = wr_cnt;
        for (int i = 0; i < 32; i++) strobe(24'(100 + i));
        check("b2_wr_cnt", wr_cnt - base, 32'd32);
        check("b2_wr0", {19'd0, wr_sel[base], wr_addr[base]}, {19'd0, 3'd2, 10'd0});
        check("b2_wr0_data", {8'd0, wr_data[base]}, 32'd100);
        check("b2_wr16", {19'd0, wr_sel[base+16], wr_addr[base+16]}, {19'd0, 3'd3, 10'd0});
        check("b2_wr31", {19'd0, wr_sel[base+31], wr_addr[base+31]}, {19'd0, 3'd3, 10'd15});
        strobe(24'd200);
        check("b2_suppress", wr_cnt - base, 32'd32);
        gpio_ctrl = C_LAST;
        cycles(4);
        strobe(24'd201);
        cycles(3);
        check("b2_start_cnt", start_cnt, 32'd2);
        check("b2_last_suppressed", wr_cnt - base, 32'd32);
        check("b2_sel_parked", {29'd0, mem_sel}, 32'd4);

        // 6. Reset during RUN
        rst_n = 1'b0;
        cycles(2);
        check("mid_rst_outs", {30'd0, led, conv_start}, 32'd0);
        check("mid_rst_size", {22'd0, img_size}, 32'd0);
        check("mid_rst_sel", {29'd0, mem_sel}, 32'd0);
        gpio_ctrl = C_SIZE;
        gpio_data = 24'd15;
        rst_n = 1'b1;
        cycles(5);
        gpio_ctrl = C_LOAD;
        cycles(4);
        base = wr_cnt;
        strobe(24'h55);
        check("post_rst_cnt", wr_cnt - base, 32'd1);
        check("post_rst_sel0", {19'd0, wr_sel[base], wr_addr[base]}, 32'd0);
        check("post_rst_data", {8'd0, wr_data[base]}, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gpio_conv_sequencer.md
Name: gpio_conv_sequencer

Overview:
- Sequencer between the MCU GPIO command word and the 2D-convolution datapath (kernel registers, image line memories, convolution engine).
- Decodes the GPIO ctrl field and edge-detects the GPIO valid strobe.
- Generates kernel and memory write strobes with address counters, and launches the convolution.
- Raises o_led when results are ready and sequences readback of results onto the GPIO return word.

Parameters:
- N, 2, number of output line memories per batch; the first batch loads N+2 input memories.
- NB_DATA, 24, GPIO data width.
- NB_ADDR, 10, memory address and image-size width.
- NB_SEL, 3, memory-select width (must hold N+2).
- NB_OUT, 13, result width.

Ports:
- CLK100MHZ  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_gpio_data  in  NB_DATA  GPIO payload; asynchronous to the clock.
- i_gpio_ctrl  in  3  command: 000 KERNEL, 001 SIZE, 010 LOAD, 100 LAST, 011 READ; others NOP.
- i_gpio_valid  in  1  host strobe, level held for many clocks; asynchronous.
- o_kernel_we  out  1  one-cycle kernel row write.
- o_kernel_row  out  2  kernel row 0..2.
- o_kernel_data  out  NB_DATA  three 8-bit coefficients.
- o_img_size  out  NB_ADDR  latched image size S.
- o_mem_we  out  1  one-cycle image write.
- o_mem_sel  out  NB_SEL  target memory.
- o_mem_addr  out  NB_ADDR  write address.
- o_mem_wdata  out  NB_DATA  pixel word.
- o_conv_start  out  1  one-cycle convolution launch.
- i_conv_done  in  1  one-cycle convolution completion.
- o_rd_sel  out  NB_SEL  result memory select.
- o_rd_addr  out  NB_ADDR  result address.
- i_rd_data  in  NB_OUT  result memory data, 1-cycle read latency.
- o_gpio_out  out  NB_OUT  result presented to GPIO.
- o_led  out  1  results ready.

Behaviour:
- Input synchronisation:
  - i_gpio_ctrl, i_gpio_valid and i_gpio_data pass through 2-flop synchronisers.
  - vld_rise = sync_valid & ~prev_valid.
  - All actions below key on vld_rise and use the synchronised ctrl and data.
- Reset values: all outputs 0; all counters 0; first_batch=1; FSM in IDLE.
- FSM states: IDLE, KLOAD, ILOAD, RUN, READY.
- KERNEL:
  - vld_rise gives o_kernel_we=1 for one cycle, o_kernel_row=krow, o_kernel_data=data, then krow++.
  - krow saturates at 2; writes beyond the 3rd are repeated on row 2.
  - Entering KERNEL from any other command clears krow.
- SIZE: o_img_size <= data[NB_ADDR-1:0] every cycle while ctrl==SIZE (level sampled, no strobe needed).
- LOAD (IDLE/READY -> ILOAD on ctrl==LOAD):
  - Entry clears the column counter; mem_sel = 0 if first_batch, else 2.
  - Each vld_rise gives o_mem_we one cycle at (mem_sel, col).
  - When col==S: col <= 0 and mem_sel++; each memory receives S+1 words.
  - Writes with mem_sel > N+1 are suppressed.
- LAST (ctrl==LAST):
  - The next vld_rise performs a normal write.
  - o_conv_start pulses the cycle after that write; first_batch <= 0; state -> RUN.
- RUN: waits for i_conv_done; then o_led <= 1 and state -> READY. Commands other than KERNEL/SIZE are ignored in RUN.
- READ (READY with ctrl==READ):
  - o_rd_sel and o_rd_addr driven from the read counters; o_gpio_out <= i_rd_data, i.e. valid 2 cycles after an address change.
  - The first word is presented before any strobe.
  - Each vld_rise advances rd_addr; at rd_addr==S-2 it wraps to 0 and rd_sel++.
  - Past word N*(S-1)-1 the pointer holds (saturates).
- READY -> ILOAD on ctrl==LOAD: o_led <= 0 and read counters cleared.
- Reset mid-operation aborts immediately to reset values, including first_batch=1.
- Simultaneous events:
  - A ctrl change and vld_rise in the same cycle: the strobe is applied under the new ctrl.
  - i_conv_done outside RUN is ignored.

Test Plan:
1. Reset, ctrl=KERNEL, three strobes with 002000/208020/002000 -> o_kernel_we pulses with rows 0,1,2 and matching data; a 4th strobe rewrites row 2.
2. ctrl=SIZE, data=15, no strobe -> o_img_size=15 within 3 clocks.
3. First batch, S=15, LOAD with 63 strobes then LAST with 1 strobe -> 64 writes, sel 0..3 at addr 0..15 each; o_conv_start pulses once after the final write.
4. Pulse i_conv_done 50 cycles later -> o_led=1; ctrl=READ -> o_gpio_out tracks sel0 addr0; 14 strobes move to sel1 addr0; extra strobes beyond 28 words hold sel1 addr13.
5. Second batch: ctrl=LOAD -> o_led=0 and writes start at sel 2; 32 strobes cover sel 2..3.
6. Assert i_rst_n=0 during RUN -> o_led, o_conv_start and counters at 0; next LOAD starts at sel 0.
